// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the PC, drives it to imem and captures PC/inst/status into IF/ID.
// Latency: imem_pc is combinational from pc_q; the fetched word appears in IF/ID one cycle later.
// Backpressure: stall holds PC, IF/ID, halt flag and counter; redirect overrides stall and squashes.
//
// Ports:
//   clk, rst_n           core clock, synchronous active-low reset
//   imem_pc / imem_inst  fetch address out, instruction word back in the same cycle
//   stall                decode cannot accept this cycle
//   redirect(_target)    taken branch/jump: load new PC and squash IF/ID
//   if_id_*              IF/ID pipeline register (pc, inst, valid, err)
//   fetch_halted         fetch parked on a fault until the next redirect
//   fetch_cnt            number of valid instructions captured into IF/ID
module ifetch_stage #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          IMEM_ADDR_BITS = 20,
    parameter logic [31:0] NOP_INST       = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic [1:0]  if_id_err,
    output logic        fetch_halted,
    output logic [31:0] fetch_cnt
);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_MIS  = 2'b01;
    localparam logic [1:0] ERR_OOR  = 2'b10;

    // Bits of the PC that are backed by instruction memory. Built as a mask so
    // IMEM_ADDR_BITS=32 (whole address space backed) needs no empty slice.
    localparam logic [31:0] ADDR_MASK = (IMEM_ADDR_BITS >= 32) ? 32'hFFFF_FFFF
                                      : ((32'd1 << IMEM_ADDR_BITS) - 32'd1);

    logic [31:0] pc_q,       pc_d;
    logic [31:0] id_pc_q,    id_pc_d;
    logic [31:0] id_inst_q,  id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic [1:0]  id_err_q,   id_err_d;
    logic        halted_q,   halted_d;
    logic [31:0] cnt_q,      cnt_d;

    logic        mis;
    logic        oor;
    logic [1:0]  fault_code;

    assign mis        = (pc_q[1:0] != 2'b00);
    assign oor        = ((pc_q & ~ADDR_MASK) != 32'd0);
    // Misalignment wins when both faults apply.
    assign fault_code = mis ? ERR_MIS : (oor ? ERR_OOR : ERR_NONE);

    always_comb begin
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        id_err_d   = id_err_q;
        halted_d   = halted_q;
        cnt_d      = cnt_q;

        if (redirect) begin
            // Squashed slot keeps the old if_id_pc; it is accepted even under stall.
            pc_d       = redirect_target;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
            id_err_d   = ERR_NONE;
            halted_d   = 1'b0;
        end else if (stall) begin
            // hold everything
        end else if (halted_q) begin
            // Fault entry was already presented once; bubble until redirected.
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
            id_err_d   = ERR_NONE;
        end else if (fault_code != ERR_NONE) begin
            // imem_inst is not trusted here (memory may float it on misaligned fetch).
            id_pc_d    = pc_q;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
            id_err_d   = fault_code;
            halted_d   = 1'b1;
        end else begin
            id_pc_d    = pc_q;
            id_inst_d  = imem_inst;
            id_valid_d = 1'b1;
            id_err_d   = ERR_NONE;
            pc_d       = pc_q + 32'd4;
            cnt_d      = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            id_pc_q    <= 32'd0;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
            id_err_q   <= ERR_NONE;
            halted_q   <= 1'b0;
            cnt_q      <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            id_err_q   <= id_err_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_pc      = pc_q;
    assign if_id_pc     = id_pc_q;
    assign if_id_inst   = id_inst_q;
    assign if_id_valid  = id_valid_q;
    assign if_id_err    = id_err_q;
    assign fetch_halted = halted_q;
    assign fetch_cnt    = cnt_q;

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
Instruction-fetch stage of the RV32 core. It owns the architectural PC and drives it to the instruction memory as a combinational address. It samples the returned instruction word in the same cycle and registers PC, instruction and status into the IF/ID pipeline register consumed by decode. It handles decode stalls, branch/jump redirects, and alignment/range fetch faults, and it keeps a fetch counter for performance monitoring.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_ADDR_BITS, 20, byte-address bits backed by instruction memory; PC[31:IMEM_ADDR_BITS] must be zero
NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0) written into IF/ID when no valid instruction is held

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
imem_pc  output  32  fetch address to instruction memory; equals pc_q combinationally
imem_inst  input  32  instruction word returned combinationally for imem_pc
stall  input  1  decode cannot accept; hold PC and IF/ID
redirect  input  1  branch/jump taken; load redirect_target and squash
redirect_target  input  32  new PC on redirect
if_id_pc  output  32  PC of held instruction
if_id_inst  output  32  held instruction, or NOP_INST when not valid
if_id_valid  output  1  IF/ID holds a real instruction
if_id_err  output  2  fault code: 00 none, 01 misaligned, 10 out-of-range
fetch_halted  output  1  fetch stopped on a fault; waits for redirect
fetch_cnt  output  32  count of valid instructions captured into IF/ID

Behaviour:
- Reset (rst_n=0 at an edge) sets these values:
  - pc_q=RESET_PC, if_id_pc=0, if_id_inst=NOP_INST, if_id_valid=0, if_id_err=00, fetch_halted=0, fetch_cnt=0.
  - Reset overrides every other input, including in mid-stall, mid-fault and with redirect asserted.
- imem_pc=pc_q at all times. The instruction for pc_q appears at IF/ID one cycle later (1-cycle fetch latency).
- Fault check on pc_q, combinational:
  - mis = (pc_q[1:0]!=0).
  - oor = (pc_q[31:IMEM_ADDR_BITS]!=0).
  - If both are set, mis has priority and the code is 01.
- Per-edge priority: reset > redirect > stall > halted > fault > normal.
- redirect=1:
  - pc_q<=redirect_target.
  - IF/ID squashed: valid=0, inst=NOP_INST, err=00, if_id_pc unchanged.
  - fetch_halted<=0.
  - redirect wins over a simultaneous stall, so the squashed slot is accepted.
- stall=1 and no redirect: pc_q, all IF/ID registers, fetch_halted and fetch_cnt hold.
- fetch_halted=1, no redirect, no stall:
  - pc_q holds.
  - IF/ID <= valid=0, inst=NOP_INST, err=00. The fault entry is presented exactly once.
- Fault (mis or oor), not halted, no redirect/stall:
  - IF/ID <= pc=pc_q, inst=NOP_INST, valid=0, err=fault code.
  - pc_q holds; fetch_halted<=1.
  - imem_inst is ignored, since memory drives Z on misaligned addresses.
- Normal:
  - IF/ID <= pc=pc_q, inst=imem_inst, valid=1, err=00.
  - pc_q<=pc_q+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0; the out-of-range check catches the preceding addresses when IMEM_ADDR_BITS<32.
  - fetch_cnt<=fetch_cnt+1, wrapping at 2^32 to 0.
- fetch_cnt changes only on normal captures. Redirect, stall, fault and halted cycles leave it unchanged.
- Outputs are registered except imem_pc. There is no combinational path from stall/redirect to any output.

Test Plan:
- Reset then run: rst_n low 2 cycles, memory[0..2]=13,93,113 (hex words) -> cycles 1..3 after release show if_id_pc=0,4,8 with valid=1 and the matching inst; fetch_cnt=3; imem_pc=C.
- Stall: assert stall 3 cycles while if_id_pc=4 -> imem_pc stays 8, IF/ID stays pc=4, fetch_cnt frozen. Release -> next edge if_id_pc=8.
- Redirect with stall: redirect=1, stall=1, target=100 hex -> next edge imem_pc=100, valid=0, inst=00000013. The following edge captures pc=100 valid=1.
- Misaligned: redirect target 102 hex -> next edge squash; following edge if_id_err=01, valid=0, fetch_halted=1, imem_pc stays 102 for 5 cycles with err=00 after the first. Redirect to 200 hex -> resumes, halted=0.
- Out-of-range: redirect to 0010_0000 with IMEM_ADDR_BITS=20 -> if_id_err=10, halted=1, fetch_cnt unchanged.
- Reset mid-fault: halted=1 at pc=102, rst_n low with redirect=1 -> imem_pc=RESET_PC, halted=0, valid=0, fetch_cnt=0.
